// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-add multiplier demo.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   MULT_W / PROD_W / NUM_DIGITS : operand width, product width, hex digit count
//   state_t                      : multiplier FSM states
//   SEG_BLANK, SEG_LUT           : active-low seven-segment codes {dp,g,f,e,d,c,b,a}
package shift_add_mult_pkg;

   localparam int MULT_W     = 8;
   localparam int PROD_W     = 2 * MULT_W;
   localparam int NUM_DIGITS = PROD_W / 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // All segments off (active-low), decimal point off.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Hex digit -> segment code, indexed by nibble value 0..F.
   localparam logic [7:0] SEG_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0,
      8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83,
      8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic logic [7:0] seg_lookup(input logic [3:0] nib);
      return SEG_LUT[nib];
   endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// One hex digit to seven-segment code (active-low, dp held off).
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   hex_i  in  4  nibble to display
//   seg_o  out 8  segment code {dp,g,f,e,d,c,b,a}
module hex_seg_decode
   import shift_add_mult_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = seg_lookup(hex_i);
   end

endmodule

// File: rtl/shift_add_mult_hex.sv
// Sequential unsigned W x W shift-add multiplier with four hex seven-segment outputs.
// Latency: result updates 10 edges after start is seen, counting the start edge (1 load, W run, 1 done).
// Backpressure: none; a start while busy is dropped, operand capture is always accepted.
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         synchronous, active-high
//   load          active-low start button; a falling edge starts a multiply
//   aOrb          operand select for capture: 0 = A, 1 = B
//   set           active-low operand capture enable
//   currIn [W]    operand data from the switches
//   result [2W]   registered product, holds its old value while a multiply runs
//   busy          high in RUN and DONE
//   disp0..disp3  segment codes for result nibbles [3:0] .. [15:12]
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (disp0 always shows a digit).
module shift_add_mult_hex
   import shift_add_mult_pkg::*;
#(
   parameter int W      = MULT_W,
   parameter int DIGITS = NUM_DIGITS   // must equal 2*W/4; four disp ports exist
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           aOrb,
   input  logic           set,
   input  logic [W-1:0]   currIn,
   output logic [2*W-1:0] result,
   output logic           busy,
   output logic [7:0]     disp0,
   output logic [7:0]     disp1,
   output logic [7:0]     disp2,
   output logic [7:0]     disp3
);

   localparam int               CW   = $clog2(W);
   localparam logic [CW-1:0]    LAST = CW'(W - 1);

   // ------------------------------------------------------------------
   // Operand registers and start edge detect
   // ------------------------------------------------------------------
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic         load_prev_q;
   logic         start_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q         <= '0;
         b_q         <= '0;
         load_prev_q <= 1'b0;   // a button held down through reset must not start
      end else begin
         load_prev_q <= load;
         if (!set) begin
            if (aOrb) b_q <= currIn;
            else      a_q <= currIn;
         end
      end
   end

   // Falling edge of the active-low button.
   assign start_d = load_prev_q && !load;

   // ------------------------------------------------------------------
   // Multiplier datapath
   // ------------------------------------------------------------------
   state_t           state_q;
   logic [W-1:0]     mcand_q;
   logic [2*W-1:0]   prod_q;
   logic [CW-1:0]    cnt_q;
   logic [2*W-1:0]   result_q;
   logic             busy_q;

   logic [W:0]       sum_d;
   logic [2*W-1:0]   prod_d;

   // Upper half plus (optionally) the multiplicand. The 9-bit sum keeps
   // its carry, which becomes the top product bit after the right shift.
   always_comb begin
      sum_d  = {1'b0, prod_q[2*W-1:W]};
      if (prod_q[0]) begin
         sum_d = {1'b0, prod_q[2*W-1:W]} + {1'b0, mcand_q};
      end
      prod_d = {sum_d, prod_q[W-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_d) begin
                  // Latch working copies so operand capture stays free while busy.
                  mcand_q <= a_q;
                  prod_q  <= {W'(0), b_q};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               result_q <= prod_q;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign result = result_q;
   assign busy   = busy_q;

   // ------------------------------------------------------------------
   // Seven-segment outputs
   // ------------------------------------------------------------------
   logic [7:0] seg [DIGITS];

`ifdef LEADING_ZERO_BLANK_EN
   // lead_zero[i]: nibble i and every nibble above it are zero.
   logic [DIGITS-1:1] nib_zero;
   logic [DIGITS-1:1] lead_zero;

   always_comb begin
      nib_zero  = '0;
      lead_zero = '0;
      for (int i = 1; i < DIGITS; i++) begin
         nib_zero[i] = (result_q[4*i +: 4] == 4'h0);
      end
      lead_zero[DIGITS-1] = nib_zero[DIGITS-1];
      for (int i = DIGITS - 2; i >= 1; i--) begin
         lead_zero[i] = nib_zero[i] && lead_zero[i+1];
      end
   end
`endif

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      logic [7:0] raw;

      hex_seg_decode u_dec (
         .hex_i (result_q[4*g +: 4]),
         .seg_o (raw)
      );

`ifdef LEADING_ZERO_BLANK_EN
      if (g == 0) begin : g_keep
         assign seg[g] = raw;
      end else begin : g_blank
         assign seg[g] = lead_zero[g] ? SEG_BLANK : raw;
      end
`else
      assign seg[g] = raw;
`endif
   end

   assign disp0 = seg[0];
   assign disp1 = seg[1];
   assign disp2 = seg[2];
   assign disp3 = seg[3];

endmodule

// File: tb/tb_shift_add_mult_hex.sv
// Directed bench for shift_add_mult_hex: vector table of products plus
// hand-written sequences for held button, start while busy, and reset mid-run.
module tb_shift_add_mult_hex;

   logic        clk;
   logic        reset;
   logic        load;
   logic        aOrb;
   logic        set;
   logic [7:0]  currIn;
   logic [15:0] result;
   logic        busy;
   logic [7:0]  disp0, disp1, disp2, disp3;

   int tests;
   int fails;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   shift_add_mult_hex dut (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .aOrb   (aOrb),
      .set    (set),
      .currIn (currIn),
      .result (result),
      .busy   (busy),
      .disp0  (disp0),
      .disp1  (disp1),
      .disp2  (disp2),
      .disp3  (disp3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic [7:0]  d3, d2, d1, d0;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected segment code, with leading-zero blanking when that build option is on.
   function automatic logic [7:0] exp_seg(input logic [15:0] r, input int i, input logic [7:0] code);
      if (BLANK_EN && i > 0 && ((r >> (4 * i)) == 16'h0)) return 8'hFF;
      return code;
   endfunction

   task automatic chk_disp(input string tag, input logic [15:0] r,
                           input logic [7:0] e3, input logic [7:0] e2,
                           input logic [7:0] e1, input logic [7:0] e0);
      chk({tag, " disp0"}, disp0, exp_seg(r, 0, e0));
      chk({tag, " disp1"}, disp1, exp_seg(r, 1, e1));
      chk({tag, " disp2"}, disp2, exp_seg(r, 2, e2));
      chk({tag, " disp3"}, disp3, exp_seg(r, 3, e3));
   endtask

   task automatic capture(input logic sel, input logic [7:0] val);
      @(negedge clk);
      set    = 1'b0;
      aOrb   = sel;
      currIn = val;
      @(negedge clk);
      set    = 1'b1;
   endtask

   // Press load for two edges; edge 1 is the start edge, edge 10 writes result.
   task automatic mult_run(input logic [15:0] exp, input logic [15:0] old, input string tag);
      @(negedge clk);
      load = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) load = 1'b1;
         if (k == 1) chk({tag, " busy after start"}, busy, 1);
         if (k == 4) chk({tag, " result mid-run"}, result, old);
         if (k == 9) begin
            chk({tag, " result before done"}, result, old);
            chk({tag, " busy before done"}, busy, 1);
         end
      end
      chk({tag, " result"}, result, exp);
      chk({tag, " busy after done"}, busy, 0);
   endtask

   initial begin
      logic [15:0] last_res;
      tests = 0;
      fails = 0;

      vecs[0] = '{8'd20,  8'd23,  16'h01CC, 8'hC0, 8'hF9, 8'hC6, 8'hC6};
      vecs[1] = '{8'd255, 8'd255, 16'hFE01, 8'h8E, 8'h86, 8'hC0, 8'hF9};
      vecs[2] = '{8'd0,   8'd77,  16'h0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
      vecs[3] = '{8'd171, 8'd205, 16'h88EF, 8'h80, 8'h80, 8'h86, 8'h8E};
      vecs[4] = '{8'd1,   8'd255, 16'h00FF, 8'hC0, 8'hC0, 8'h8E, 8'h8E};
      vecs[5] = '{8'd16,  8'd16,  16'h0100, 8'hC0, 8'hF9, 8'hC0, 8'hC0};
      vecs[6] = '{8'd13,  8'd11,  16'h008F, 8'hC0, 8'hC0, 8'h80, 8'h8E};

      // ---------------- reset state ----------------
      reset  = 1'b1;
      load   = 1'b1;
      set    = 1'b1;
      aOrb   = 1'b0;
      currIn = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset result", result, 0);
      chk("reset busy", busy, 0);
      chk_disp("reset", 16'h0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      @(negedge clk);
      reset = 1'b0;
      last_res = 16'h0000;

      // ---------------- vector table ----------------
      for (int v = 0; v < 7; v++) begin
         string tag;
         tag = $sformatf("vec%0d %0d*%0d", v, vecs[v].a, vecs[v].b);
         capture(1'b0, vecs[v].a);
         capture(1'b1, vecs[v].b);
         mult_run(vecs[v].res, last_res, tag);
         chk_disp(tag, vecs[v].res, vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0);
         last_res = vecs[v].res;
      end

      // ---------------- 0*77 with load held low ----------------
      capture(1'b0, 8'd0);
      capture(1'b1, 8'd77);
      @(negedge clk);
      load = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 9) chk("hold busy before done", busy, 1);
      end
      chk("hold result", result, 0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold no restart busy c%0d", k), busy, 0);
      end
      chk("hold result after", result, 0);
      @(negedge clk);
      load = 1'b1;
      last_res = 16'h0000;

      // ---------------- 7*9, second press and A change mid-run ----------------
      capture(1'b0, 8'd7);
      capture(1'b1, 8'd9);
      @(negedge clk);
      load = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) load = 1'b1;
         if (k == 3) begin
            load   = 1'b0;   // second falling edge lands during RUN
            set    = 1'b0;
            aOrb   = 1'b0;
            currIn = 8'd200;
         end
         if (k == 4) begin
            load = 1'b1;
            set  = 1'b1;
         end
         if (k == 9) chk("busy-start result before done", result, last_res);
      end
      chk("busy-start result 7*9", result, 16'h003F);
      chk("busy-start busy after", busy, 0);
      chk_disp("7*9", 16'h003F, 8'hC0, 8'hC0, 8'hB0, 8'h8E);
      repeat (12) @(posedge clk);
      #1;
      chk("ignored start stays idle", busy, 0);
      chk("ignored start result kept", result, 16'h003F);
      // A was recaptured mid-run; B still 9.
      mult_run(16'h0708, 16'h003F, "200*9");
      chk_disp("200*9", 16'h0708, 8'hC0, 8'hF8, 8'hC0, 8'h80);
      last_res = 16'h0708;

      // ---------------- reset during RUN ----------------
      capture(1'b0, 8'd20);
      capture(1'b1, 8'd23);
      @(negedge clk);
      load = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) load = 1'b1;
      end
      chk("abort busy before reset", busy, 1);
      reset = 1'b1;            // sampled on the 4th RUN edge
      @(posedge clk);
      #1;
      chk("abort result", result, 0);
      chk("abort busy", busy, 0);
      chk_disp("abort", 16'h0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("abort stays idle", busy, 0);
      capture(1'b0, 8'd20);
      capture(1'b1, 8'd23);
      mult_run(16'h01CC, 16'h0000, "after abort 20*23");
      chk_disp("after abort", 16'h01CC, 8'hC0, 8'hF9, 8'hC6, 8'hC6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
